clk_div_prog: RTL and testbench

Programmable, runtime-reloadable clock divider and tick generator, the parametrised successor to the fixed half-period toggle counter. It runs on the single system clock and produces one of two outputs for downstream logic such as VGA stripe timing and blink logic:
- a divided square wave, or
- a one-cycle strobe.

The divisor is reloaded glitch-free at period boundaries.

---
 rtl/clk_div_prog.sv | 149 ++++++++++++++
 tb/tb_clk_div_prog.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable, runtime-reloadable clock divider / tick generator.
// Produces either a divided square wave (toggle mode) or a one-cycle strobe
// (pulse mode) on y, plus a per-wrap tick. New divisors are staged in a
// pending register and only take effect at a period boundary, so the output
// never sees a truncated or stretched period caused by a mid-period reload.
module clk_div_prog #(
  parameter int unsigned           WIDTH       = 26,
  parameter logic [WIDTH-1:0]      DEFAULT_DIV = 60000000
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             y,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             load_ack,
  output logic             load_err
);

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // State registers and their next-state values
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] d_act_q,  d_act_d;
  logic [WIDTH-1:0] d_pend_q, d_pend_d;
  logic             pend_v_q, pend_v_d;
  mode_e            mode_q,   mode_d;
  logic             y_q,      y_d;
  logic             tick_q,   tick_d;
  logic             load_ack_q, load_ack_d;
  logic             load_err_q, load_err_d;

  // Decoded per-cycle conditions
  mode_e            mode_in;
  logic             last_cnt;
  logic             wrap;
  logic             load_ok;
  logic             load_bad;

  assign mode_in  = mode_e'(mode);
  // D_act is never 0, so D_act-1 cannot underflow; >= guards against any
  // count that somehow exceeds the active divisor.
  assign last_cnt = (count_q >= (d_act_q - ONE));
  assign wrap     = en && last_cnt;
  assign load_ok  = div_load && (div_in != '0);
  assign load_bad = div_load && (div_in == '0);

  // Next-state: counter, divisor staging/apply, mode latch and output shaping
  always_comb begin
    count_d    = count_q;
    d_act_d    = d_act_q;
    d_pend_d   = d_pend_q;
    pend_v_d   = pend_v_q;
    mode_d     = mode_q;
    y_d        = y_q;
    tick_d     = 1'b0;
    load_ack_d = 1'b0;
    load_err_d = load_bad;

    // In pulse mode y mirrors tick, so it is low on every non-wrap edge.
    if (mode_q == MODE_PULSE) begin
      y_d = 1'b0;
    end

    if (wrap) begin
      count_d = '0;
      tick_d  = 1'b1;
      mode_d  = mode_in;
      if (mode_in == MODE_PULSE) begin
        y_d = 1'b1;
      end else if (mode_q == MODE_PULSE) begin
        // Leaving pulse mode: start the square wave high on this wrap.
        y_d = 1'b1;
      end else begin
        y_d = ~y_q;
      end
      // A load landing on the wrap cycle bypasses the pending register and
      // supersedes anything already pending.
      if (load_ok) begin
        d_act_d    = div_in;
        pend_v_d   = 1'b0;
        load_ack_d = 1'b1;
      end else if (pend_v_q) begin
        d_act_d    = d_pend_q;
        pend_v_d   = 1'b0;
        load_ack_d = 1'b1;
      end
    end else if (!en && pend_v_q) begin
      // Idle with a pending divisor: apply immediately and restart the count
      // so the new divisor always begins from zero.
      count_d    = '0;
      d_act_d    = d_pend_q;
      pend_v_d   = 1'b0;
      load_ack_d = 1'b1;
      if (load_ok) begin
        d_pend_d = div_in;
        pend_v_d = 1'b1;
      end
    end else begin
      if (en) begin
        count_d = count_q + ONE;
      end
      if (load_ok) begin
        d_pend_d = div_in;
        pend_v_d = 1'b1;
      end
    end
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk1) begin
    if (rst) begin
      count_q    <= '0;
      d_act_q    <= DEFAULT_DIV;
      d_pend_q   <= DEFAULT_DIV;
      pend_v_q   <= 1'b0;
      mode_q     <= MODE_TOGGLE;
      y_q        <= 1'b0;
      tick_q     <= 1'b0;
      load_ack_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      d_act_q    <= d_act_d;
      d_pend_q   <= d_pend_d;
      pend_v_q   <= pend_v_d;
      mode_q     <= mode_d;
      y_q        <= y_d;
      tick_q     <= tick_d;
      load_ack_q <= load_ack_d;
      load_err_q <= load_err_d;
    end
  end

  assign y        = y_q;
  assign tick     = tick_q;
  assign count    = count_q;
  assign load_ack = load_ack_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog (WIDTH=8, DEFAULT_DIV=5).
// Inputs change 1 time unit after each rising edge; outputs are checked at
// the same point, i.e. they reflect the edge just taken.
module tb_clk_div_prog;

  logic       clk1;
  logic       rst;
  logic       en;
  logic       mode;
  logic       div_load;
  logic [7:0] div_in;
  logic       y;
  logic       tick;
  logic [7:0] count;
  logic       load_ack;
  logic       load_err;

  int unsigned nerr;
  int unsigned nchk;

  clk_div_prog #(
    .WIDTH      (8),
    .DEFAULT_DIV(8'd5)
  ) dut (
    .clk1    (clk1),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .div_load(div_load),
    .div_in  (div_in),
    .y       (y),
    .tick    (tick),
    .count   (count),
    .load_ack(load_ack),
    .load_err(load_err)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int unsigned cyc,
                           input int unsigned c, input bit t, input bit yy,
                           input bit ack, input bit err);
    chk($sformatf("%s@%0d.count", tag, cyc), int'(count), c);
    chk($sformatf("%s@%0d.tick", tag, cyc), int'(tick), int'(t));
    chk($sformatf("%s@%0d.y", tag, cyc), int'(y), int'(yy));
    chk($sformatf("%s@%0d.load_ack", tag, cyc), int'(load_ack), int'(ack));
    chk($sformatf("%s@%0d.load_err", tag, cyc), int'(load_err), int'(err));
  endtask

  initial begin
    nerr = 0;
    nchk = 0;
    rst = 1'b1; en = 1'b0; mode = 1'b0; div_load = 1'b0; div_in = 8'd0;
    step(); step();
    chk_state("reset", 0, 0, 0, 0, 0, 0);

    // Toggle mode, D=5: tick every 5, y period 10
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk_state("toggle5", i, i % 5, (i % 5) == 0, ((i / 5) % 2) == 1, 0, 0);
    end

    // Pulse mode requested mid-run; takes effect at the wrap on edge 15
    mode = 1'b1;
    for (int i = 11; i <= 20; i++) begin
      step();
      chk_state("pulse5", i, i % 5, (i % 5) == 0, (i >= 15) && ((i % 5) == 0), 0, 0);
    end

    // Back to toggle mid-period: y goes 1 at the next wrap (25), toggles at 30
    for (int i = 21; i <= 22; i++) begin
      step();
      chk_state("pulse_mid", i, i % 5, 0, 0, 0, 0);
    end
    mode = 1'b0;
    for (int i = 23; i <= 30; i++) begin
      step();
      chk_state("p2t", i, i % 5, (i % 5) == 0, (i >= 25) && (i < 30), 0, 0);
    end

    // Load 3 at count=1: period stays 5 until wrap at edge 35, then 3
    step();
    chk_state("pre_load3", 31, 1, 0, 0, 0, 0);
    div_load = 1'b1; div_in = 8'd3;
    step();
    chk_state("load3", 32, 2, 0, 0, 0, 0);
    div_load = 1'b0;
    for (int i = 33; i <= 41; i++) begin
      step();
      if (i < 35)
        chk_state("load3_wait", i, i % 5, 0, 0, 0, 0);
      else
        chk_state("div3", i, (i - 35) % 3, ((i - 35) % 3) == 0,
                  (i < 38) || (i == 41), i == 35, 0);
    end

    // Load 3 then 7 before the wrap: last wins, period becomes 7
    div_load = 1'b1; div_in = 8'd3;
    step();
    chk_state("last_win_a", 42, 1, 0, 1, 0, 0);
    div_in = 8'd7;
    step();
    chk_state("last_win_b", 43, 2, 0, 1, 0, 0);
    div_load = 1'b0;
    step();
    chk_state("apply7", 44, 0, 1, 0, 1, 0);
    for (int i = 45; i <= 57; i++) begin
      step();
      chk_state("div7", i, (i - 44) % 7, ((i - 44) % 7) == 0, i >= 51, 0, 0);
    end

    // Load 2 during the wrap cycle (count=6): applies directly at that wrap
    div_load = 1'b1; div_in = 8'd2;
    step();
    chk_state("wrap_load2", 58, 0, 1, 0, 1, 0);
    div_load = 1'b0;
    for (int i = 59; i <= 62; i++) begin
      step();
      chk_state("div2", i, (i - 58) % 2, ((i - 58) % 2) == 0, (i == 60) || (i == 61), 0, 0);
    end

    // Load 1 in the wrap cycle: tick every cycle, y toggles every cycle
    step();
    chk_state("pre_load1", 63, 1, 0, 0, 0, 0);
    div_load = 1'b1; div_in = 8'd1;
    step();
    chk_state("wrap_load1", 64, 0, 1, 1, 1, 0);
    div_load = 1'b0;
    for (int i = 65; i <= 68; i++) begin
      step();
      chk_state("div1", i, 0, 1, (i % 2) == 0, 0, 0);
    end

    // Zero divisor is rejected: load_err pulses, D_act stays 1
    div_load = 1'b1; div_in = 8'd0;
    step();
    chk_state("zero_err", 69, 0, 1, 0, 0, 1);
    div_load = 1'b0;
    step();
    chk_state("zero_after", 70, 0, 1, 1, 0, 0);

    // Restore D=5, then idle at count=3 and load 6 while en=0
    div_load = 1'b1; div_in = 8'd5;
    step();
    chk_state("restore5", 71, 0, 1, 0, 1, 0);
    div_load = 1'b0;
    for (int i = 72; i <= 74; i++) begin
      step();
      chk_state("run5", i, i - 71, 0, 0, 0, 0);
    end
    en = 1'b0;
    step();
    chk_state("idle_hold", 75, 3, 0, 0, 0, 0);
    div_load = 1'b1; div_in = 8'd6;
    step();
    chk_state("idle_load6", 76, 3, 0, 0, 0, 0);
    div_load = 1'b0;
    step();
    chk_state("idle_apply6", 77, 0, 0, 0, 1, 0);
    step();
    chk_state("idle_after", 78, 0, 0, 0, 0, 0);
    en = 1'b1;
    for (int i = 79; i <= 84; i++) begin
      step();
      chk_state("div6", i, (i - 78) % 6, i == 84, i == 84, 0, 0);
    end

    // Reset mid-period with a pending load: pending discarded, D back to 5
    div_load = 1'b1; div_in = 8'd3;
    step();
    chk_state("pend3", 85, 1, 0, 1, 0, 0);
    div_load = 1'b0;
    step();
    chk_state("pend3_b", 86, 2, 0, 1, 0, 0);
    rst = 1'b1;
    step();
    chk_state("mid_rst", 87, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 88; i <= 92; i++) begin
      step();
      chk_state("post_rst", i, (i - 87) % 5, i == 92, i == 92, 0, 0);
    end

    // en low for 4 cycles: count and y frozen, no tick
    for (int i = 93; i <= 94; i++) begin
      step();
      chk_state("pre_freeze", i, i - 92, 0, 1, 0, 0);
    end
    en = 1'b0;
    for (int i = 95; i <= 98; i++) begin
      step();
      chk_state("freeze", i, 2, 0, 1, 0, 0);
    end
    en = 1'b1;
    for (int i = 99; i <= 101; i++) begin
      step();
      chk_state("thaw", i, (i - 96) % 5, i == 101, i != 101, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
